// File: rtl/shift_link_pkg.sv
// shift_link_pkg: shared types and helpers for the shift-register serial link blocks
// Contents: piso_state_t (transmitter FSM states) and cnt_w (bit counter width).
package shift_link_pkg;
    typedef enum logic {IDLE, SHIFT} piso_state_t;
    localparam int DEFAULT_DATA_WIDTH = 8;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready word intake
// Ports: clk, reset (async, active-high); par_valid/par_ready/par_data word handshake;
//        serial_out/serial_valid bit stream; frame_start/frame_done first/last-bit pulses;
//        busy high while a word is being shifted.
module piso_tx
    import shift_link_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  par_valid,
    output logic                  par_ready,
    input  logic [DATA_WIDTH-1:0] par_data,
    output logic                  serial_out,
    output logic                  serial_valid,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int CW = cnt_w(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    piso_state_t           state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sh;
    logic                  last;
    logic                  accept;
    // cnt is the index of the bit currently on serial_out; the first bit
    // goes straight to serial_out at load, so sh holds only the remainder.
    assign last      = state == SHIFT && cnt == LAST;
    assign par_ready = state == IDLE || last;
    assign accept    = par_valid && par_ready;
    assign busy      = state == SHIFT;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sh           <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
        end else if (accept) begin
            state        <= SHIFT;
            cnt          <= '0;
            sh           <= MSB_FIRST ? par_data << 1 : par_data >> 1;
            serial_out   <= MSB_FIRST ? par_data[DATA_WIDTH-1] : par_data[0];
            serial_valid <= 1'b1;
            frame_start  <= 1'b1;
            frame_done   <= 1'b0;
        end else if (state == SHIFT && !last) begin
            cnt          <= cnt + 1'b1;
            sh           <= MSB_FIRST ? sh << 1 : sh >> 1;
            serial_out   <= MSB_FIRST ? sh[DATA_WIDTH-1] : sh[0];
            frame_start  <= 1'b0;
            frame_done   <= cnt == LAST - 1'b1;
        end else begin
            state        <= IDLE;
            cnt          <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized and directed checks of piso_tx (MSB- and LSB-first) against a bit-queue model
module tb_piso_tx;
    typedef struct packed {
        logic bm;
        logic bl;
        logic st;
        logic dn;
    } bit_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       par_valid = 1'b0;
    logic [7:0] par_data = 8'h00;
    logic       rdy_m, so_m, sv_m, fs_m, fd_m, bz_m;
    logic       rdy_l, so_l, sv_l, fs_l, fd_l, bz_l;
    logic [7:0] rx;
    bit_t       q[$];
    logic [7:0] words[$];
    logic       acc;
    logic       done_prev = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    always #5 clk = ~clk;
    piso_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .par_valid(par_valid), .par_ready(rdy_m), .par_data(par_data),
        .serial_out(so_m), .serial_valid(sv_m), .frame_start(fs_m), .frame_done(fd_m), .busy(bz_m)
    );
    piso_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .par_valid(par_valid), .par_ready(rdy_l), .par_data(par_data),
        .serial_out(so_l), .serial_valid(sv_l), .frame_start(fs_l), .frame_done(fd_l), .busy(bz_l)
    );
    // behavioural SIPO receiver fed by the MSB-first transmitter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx <= '0;
        else if (sv_m) rx <= {rx[6:0], so_m};
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_outputs();
        bit_t e;
        logic v;
        v = q.size() != 0;
        e = v ? q[0] : '0;
        check("so_m", so_m, e.bm);
        check("so_l", so_l, e.bl);
        check("sv_m", sv_m, v);
        check("sv_l", sv_l, v);
        check("fs_m", fs_m, e.st);
        check("fs_l", fs_l, e.st);
        check("fd_m", fd_m, e.dn);
        check("fd_l", fd_l, e.dn);
        check("busy_m", bz_m, v);
        check("busy_l", bz_l, v);
        check("rdy_m", rdy_m, q.size() <= 1);
        check("rdy_l", rdy_l, q.size() <= 1);
    endtask
    task automatic cycle(input logic v, input logic [7:0] d);
        par_valid = v;
        par_data  = d;
        @(negedge clk);
        check_outputs();
        if (done_prev && words.size() != 0) check("loopback", rx, words.pop_front());
        done_prev = q.size() != 0 && q[0].dn;
        acc = v && q.size() <= 1;
        @(posedge clk);
        #1;
        if (q.size() != 0) void'(q.pop_front());
        if (acc) begin
            words.push_back(d);
            for (int i = 0; i < 8; i++) q.push_back('{bm: d[7-i], bl: d[i], st: i == 0, dn: i == 7});
        end
    endtask
    task automatic send(input logic [7:0] d);
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            cycle(1'b1, d);
            tries++;
        end
        check("send_accepted", acc, 1'b1);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_so", so_m, 1'b0);
        check("reset_busy", bz_m, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_reset", rdy_m, 1'b1);
        idle(2);
        send(8'hA5);
        idle(12);
        send(8'hFF);
        send(8'h00);
        idle(12);
        send(8'h01);
        idle(12);
        send(8'h3C);
        send(8'hC3);
        idle(12);
        send(8'h5A);
        idle(3);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_so", so_m, 1'b0);
        check("midreset_sv", sv_m, 1'b0);
        check("midreset_busy", bz_m, 1'b0);
        check("midreset_fd", fd_m, 1'b0);
        check("midreset_sv_l", sv_l, 1'b0);
        q.delete();
        words.delete();
        done_prev = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'h81);
        idle(12);
        for (int i = 0; i < 600; i++) cycle($urandom_range(0, 3) != 0, 8'($urandom));
        idle(12);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
